adc_fake_mc: RTL
================

Name: adc_fake_mc

Overview:
- Parametrised multi-channel behavioural ADC model; successor to the single-channel 8-bit ramp ADC stub.
- Produces synthetic samples (ramp, triangle, LFSR noise, constant) per channel after a programmable conversion time.
- Supports one-shot (start/ch_sel) and continuous round-robin scan.
- Sits in front of the sensor-hub sample path so the datapath, FIFO and host readout can be exercised without real converters.

Parameters:
- WIDTH, 8, sample width in bits (4..16).
- NCH, 4, number of channels (1..16).
- CHW, 2, channel index width; must satisfy 2**CHW >= NCH.
- PERIOD, 50000, conversion time in clk cycles (≥2); 50000 gives 1 ms at 50 MHz.
- TW, 16, timer width; must satisfy 2**TW >= PERIOD.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state.
- mode  in  2  waveform: 0 ramp, 1 triangle, 2 LFSR, 3 constant.
- cont  in  1  1 = continuous scan, 0 = one-shot.
- start  in  1  one-shot request, sampled in IDLE only.
- ch_sel  in  CHW  channel for one-shot.
- busy  out  1  conversion in progress.
- valid  out  1  one-cycle pulse: dout/dch updated.
- dout  out  WIDTH  sample.
- dch  out  CHW  channel of dout.
- ovr  out  1  sticky overrun flag (see Optional Feature).

Behaviour:
- Reset (async, immediate, including mid-conversion): state=IDLE, tmr=0, busy=0, valid=0, dout=0, dch=0, ovr=0.
- Per-channel generator reset values: ramp/triangle accumulator = 0, triangle direction = up, LFSR = c+1 (nonzero) for channel c.
- ena=0: FSM, timer, generators and outputs hold. valid is forced 0. A start arriving while ena=0 is ignored.
- FSM states are IDLE and CONV.
- IDLE, start=1 or cont=1:
  - cur_ch <= ch_sel if cont=0; cur_ch <= 0 if cont=1.
  - tmr <= 0, busy <= 1, go to CONV.
  - With both asserted, cont wins.
- CONV: tmr increments each enabled cycle. On the edge where tmr==PERIOD-1:
  - dout <= gen[cur_ch]; dch <= cur_ch; valid <= 1 for one cycle; gen[cur_ch] advances; tmr <= 0.
  - If cont=1 (sampled on this edge): cur_ch <= cur_ch+1, wrapping from NCH-1 to 0; stay in CONV with busy=1, so there are no gap cycles.
  - If cont=0: go to IDLE, busy <= 0.
- Latency: valid rises exactly PERIOD cycles after the edge that accepts start. In continuous mode valid repeats every PERIOD cycles.
- Dropping cont mid-conversion finishes the current conversion, then returns to IDLE.
- start while busy is ignored.
- mode is sampled at the completion edge. Changing mode does not reset generator state.
- Generators (value output first, then advance):
  - Ramp: +1 modulo 2**WIDTH (wraps max→0).
  - Triangle: up to 2**WIDTH-1, then down to 0. Direction flips when the endpoint is reached, so each endpoint is emitted once: …,max-1,max,max-1,…,1,0,1,…
  - LFSR: Galois, maximal-length taps for WIDTH; never reaches 0.
  - Constant: channel index zero-extended to WIDTH; the generator does not advance.
- Only the converted channel's generator advances.

Optional Feature:
- Macro ADC_FAKE_OVR_EN.
- Defined:
  - ovr sets when start=1 and busy=1 on an enabled edge (request lost).
  - ovr also sets in continuous mode if valid would fire while the previous valid is still high (PERIOD=1 misconfig guard).
  - ovr is sticky until rst_n, or a start accepted in IDLE with cont=0, which clears it.
- Not defined: ovr tied 0 and the overrun logic is absent.

Test Plan (PERIOD=4, WIDTH=8, NCH=4 unless noted):
- Reset value: rst_n low → busy=0, valid=0, dout=0, dch=0. Release, idle 10 cycles → no valid.
- One-shot ramp: mode=0, start with ch_sel=2 → busy high next cycle; valid exactly 4 cycles after start with dout=0, dch=2; repeat → dout=1; channel 1 start → dout=0.
- Continuous scan, triangle: cont=1, mode=1 → valid every 4 cycles, dch sequence 0,1,2,3,0. With WIDTH=2, channel 0 values are 0,1,2,3,2,1,0,1.
- LFSR: mode=2, cont=1 → channel 0 first sample 0x01, channel 3 first 0x04. 300 samples on channel 0 never 0; period 255.
- ena and reset mid-op: ena low for 5 cycles mid-CONV → valid delayed by exactly 5 cycles. rst_n low mid-CONV → immediate IDLE; next ramp sample restarts at 0.
- Overrun (ADC_FAKE_OVR_EN): start while busy → ovr=1 stays set; next accepted one-shot start clears it. Without the macro ovr stays 0.

Source files
------------

// File: rtl/adc_fake_mc_if.sv
// Control/sample bundle between the fake multi-channel ADC and its consumer.
// The ADC side uses the slave modport; the driver/consumer uses master.
interface adc_fake_mc_if #(
    parameter int WIDTH = 8,
    parameter int CHW   = 2
);
    logic             ena;
    logic [1:0]       mode;
    logic             cont;
    logic             start;
    logic [CHW-1:0]   ch_sel;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] dout;
    logic [CHW-1:0]   dch;
    logic             ovr;

    modport master (
        output ena, mode, cont, start, ch_sel,
        input  busy, valid, dout, dch, ovr
    );

    modport slave (
        input  ena, mode, cont, start, ch_sel,
        output busy, valid, dout, dch, ovr
    );
endinterface

// File: rtl/adc_fake_mc.sv
// Behavioural multi-channel ADC: synthetic ramp/triangle/LFSR/constant samples after PERIOD clocks.
// Define ADC_FAKE_OVR_EN to build the sticky overrun (lost request) flag; otherwise ovr is tied 0.
module adc_fake_mc #(
    parameter int WIDTH  = 8,
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int PERIOD = 50000,
    parameter int TW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    adc_fake_mc_if.slave  bus
);

    typedef enum logic {IDLE, CONV} state_t;

    // Galois right-shift masks (bit t-1 set for tap t) giving maximal-length sequences.
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

    localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
    localparam logic [TW-1:0]    TMR_LAST = TW'(PERIOD - 1);

    state_t           state, state_nxt;
    logic [TW-1:0]    tmr;
    logic [CHW-1:0]   cur_ch;
    logic [CHW-1:0]   start_ch;
    logic             busy_r;
    logic             valid_r;
    logic [WIDTH-1:0] dout_r;
    logic [CHW-1:0]   dch_r;
    logic             accept;
    logic             fire;

    logic [WIDTH-1:0] acc      [NCH];
    logic             dir_down [NCH];
    logic [WIDTH-1:0] lfsr     [NCH];

    logic [WIDTH-1:0] gen_val;
    logic [WIDTH-1:0] acc_nxt;
    logic             dir_nxt;
    logic [WIDTH-1:0] lfsr_nxt;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start || bus.cont) begin
                    accept    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (tmr == TMR_LAST) begin
                    fire = 1'b1;
                    if (!bus.cont)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range one-shot selections (NCH not a power of two) fall back to channel 0.
    always_comb begin
        start_ch = (int'(bus.ch_sel) < NCH) ? bus.ch_sel : '0;
    end

    // Sample value and advanced generator state for the channel being converted.
    always_comb begin
        gen_val  = '0;
        acc_nxt  = acc[cur_ch];
        dir_nxt  = dir_down[cur_ch];
        lfsr_nxt = lfsr[cur_ch];
        case (bus.mode)
            2'd0: begin
                gen_val = acc[cur_ch];
                acc_nxt = acc[cur_ch] + 1'b1;
            end
            2'd1: begin
                gen_val = acc[cur_ch];
                if (!dir_down[cur_ch]) begin
                    if (acc[cur_ch] == '1) begin
                        dir_nxt = 1'b1;
                        acc_nxt = acc[cur_ch] - 1'b1;
                    end else begin
                        acc_nxt = acc[cur_ch] + 1'b1;
                    end
                end else begin
                    if (acc[cur_ch] == '0) begin
                        dir_nxt = 1'b0;
                        acc_nxt = acc[cur_ch] + 1'b1;
                    end else begin
                        acc_nxt = acc[cur_ch] - 1'b1;
                    end
                end
            end
            2'd2: begin
                gen_val  = lfsr[cur_ch];
                lfsr_nxt = lfsr[cur_ch][0] ? ((lfsr[cur_ch] >> 1) ^ TAPS) : (lfsr[cur_ch] >> 1);
            end
            default: begin
                gen_val = WIDTH'(cur_ch);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (bus.ena)
            state <= state_nxt;
    end

    // Timer, output registers and generator bank; valid drops on every edge it is not re-fired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr     <= '0;
            cur_ch  <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            dout_r  <= '0;
            dch_r   <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc[c]      <= '0;
                dir_down[c] <= 1'b0;
                lfsr[c]     <= WIDTH'((c % ((1 << WIDTH) - 1)) + 1);
            end
        end else begin
            valid_r <= 1'b0;
            if (bus.ena) begin
                if (accept) begin
                    cur_ch <= bus.cont ? '0 : start_ch;
                    tmr    <= '0;
                    busy_r <= 1'b1;
                end else if (state == CONV) begin
                    if (fire) begin
                        tmr              <= '0;
                        dout_r           <= gen_val;
                        dch_r            <= cur_ch;
                        valid_r          <= 1'b1;
                        acc[cur_ch]      <= acc_nxt;
                        dir_down[cur_ch] <= dir_nxt;
                        lfsr[cur_ch]     <= lfsr_nxt;
                        if (bus.cont)
                            cur_ch <= (int'(cur_ch) == NCH - 1) ? '0 : cur_ch + 1'b1;
                        else
                            busy_r <= 1'b0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
            end
        end
    end

`ifdef ADC_FAKE_OVR_EN
    logic ovr_r;

    // Sticky until reset or an accepted one-shot request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_r <= 1'b0;
        end else if (bus.ena) begin
            if (accept && !bus.cont)
                ovr_r <= 1'b0;
            else if ((bus.start && busy_r) || (fire && bus.cont && valid_r))
                ovr_r <= 1'b1;
        end
    end

    assign bus.ovr = ovr_r;
`else
    assign bus.ovr = 1'b0;
`endif

    assign bus.busy  = busy_r;
    assign bus.valid = valid_r;
    assign bus.dout  = dout_r;
    assign bus.dch   = dch_r;

endmodule
